// File: rtl/lmao_serial_sub_pkg.sv
// Shared arithmetic-lab definitions: FSM state encoding and default operand sizing.
// The bit-serial adder uses this package as well.
package lmao_serial_sub_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lmao_fullsub.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit position underflows.
module lmao_fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/lmao_serial_sub.sv
// Bit-serial unsigned subtractor: A_in - B_in, LSB first through one full-subtractor cell.
//   state    | meaning
//   ST_IDLE  | waiting for Start_in, operands not yet latched
//   ST_SHIFT | one result bit per clock, WIDTH clocks
//   ST_DONE  | Diff_out/Borrow_out fresh, Done_out high for this cycle
module lmao_serial_sub
  import lmao_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic             Start_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             Busy_out,
  output logic             Done_out,
  output logic [WIDTH:0]   Diff_out,
  output logic             Borrow_out
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             d;
  logic             bout;
  logic             last_bit;

  lmao_fullsub u_fullsub (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk_in) begin
    if (Rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Start_in) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign Busy_out   = (state != ST_IDLE);
  assign Done_out   = (state == ST_DONE);
  assign Borrow_out = Diff_out[WIDTH];

  // Result bits collect in acc; Diff_out is only written on the final bit so it
  // never shows a partial difference.
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      Diff_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start_in) begin
            a_sr   <= A_in;
            b_sr   <= B_in;
            acc    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bout;
          cnt    <= cnt + CNT_W'(1);
          acc    <= {d, acc[WIDTH-1:1]};
          if (last_bit) Diff_out <= {bout, d, acc[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
